// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequencer for the MAR/MDR memory path. It arbitrates round-robin between
// the instruction-fetch requester and the load/store requester, then for
// the granted request walks IDLE -> ADDR -> ACCESS -> (CAPTURE) -> DONE.
// Along the way it drives the MAR/MDR strobes and the memory handshake.
//
// Optional feature macro: MEMCTRL_TIMEOUT_EN
//   defined   : the ACCESS wait counter is present; after WAIT_MAX ACCESS
//               cycles with no mem_ack the transaction ends in DONE with
//               err pulsed.
//   undefined : no counter; ACCESS waits for mem_ack indefinitely; err = 0.
//
// Ports
//   clock, clear_n    rising-edge clock, asynchronous active-low reset
//   if_req/if_addr    fetch request (always a read) and its address
//   if_gnt            fetch granted, ADDR through DONE
//   ls_req/ls_we/ls_addr  load/store request, 1 = store, address
//   ls_gnt            load/store granted, ADDR through DONE
//   MARin, MDRin      MAR / MDR load strobes
//   Read              MDR mux select: 1 = memory data, 0 = bus
//   mem_addr          registered address of the granted request
//   mem_rd, mem_wr    memory read / write strobes (held during ACCESS)
//   mem_ack           memory completion, only looked at in ACCESS
//   busy              high in any state other than IDLE
//   done, err         one-cycle completion pulse, timeout pulse with done
module mem_access_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              MARin,
  output logic              MDRin,
  output logic              Read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic any_req_s;   // at least one requester is asking
  logic win_ls_s;    // arbitration winner is load/store
  logic cur_ls_s;    // source of the transaction the next state belongs to
  logic cur_we_s;    // op of the transaction the next state belongs to
  logic timeout_s;   // ACCESS expires this cycle with no ack
  logic src_ls_r;    // latched source of the granted request
  logic we_r;        // latched op: 1 = store
  logic last_ls_r;   // last grant pointer: 1 = load/store granted last

  // Next-cycle output values, registered below
  logic if_gnt_s, ls_gnt_s, marin_s, mdrin_s, read_s;
  logic mem_rd_s, mem_wr_s, busy_s, done_s, err_s;

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  logic [CNT_W-1:0] cnt_r;

  // Wait counter: zero on ACCESS entry, counts ACCESS cycles
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_ACCESS) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Last permitted ACCESS cycle without an ack; an ack in that cycle still wins
  assign timeout_s = (state_r == ST_ACCESS) && !mem_ack &&
                     (cnt_r == CNT_W'(WAIT_MAX - 1));
`else
  logic unused_wait_max_s;
  assign unused_wait_max_s = (WAIT_MAX > 0);
  assign timeout_s = 1'b0;
`endif

  // Round-robin arbitration and selection of the transaction's source/op
  always_comb begin
    any_req_s = if_req | ls_req;
    // On a tie the requester that was not granted last wins
    win_ls_s  = ls_req & (~if_req | ~last_ls_r);
    if (state_r == ST_IDLE) begin
      cur_ls_s = win_ls_s;
      cur_we_s = win_ls_s & ls_we;
    end else begin
      cur_ls_s = src_ls_r;
      cur_we_s = we_r;
    end
  end

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_ack) begin
          state_s = we_r ? ST_DONE : ST_CAPTURE;
        end else if (timeout_s) begin
          // A timed-out read skips CAPTURE so the MDR is left untouched
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_CAPTURE: state_s = ST_DONE;
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Grant capture: winner, op, address and round-robin pointer
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      src_ls_r  <= 1'b0;
      we_r      <= 1'b0;
      last_ls_r <= 1'b1;
      mem_addr  <= {ADDR_W{1'b0}};
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      src_ls_r  <= win_ls_s;
      we_r      <= win_ls_s & ls_we;
      last_ls_r <= win_ls_s;
      mem_addr  <= win_ls_s ? ls_addr : if_addr;
    end else begin
      src_ls_r  <= src_ls_r;
      we_r      <= we_r;
      last_ls_r <= last_ls_r;
      mem_addr  <= mem_addr;
    end
  end

  // Output decode from the next state so registered outputs line up with it
  always_comb begin
    busy_s   = (state_s != ST_IDLE);
    if_gnt_s = busy_s & ~cur_ls_s;
    ls_gnt_s = busy_s &  cur_ls_s;
    marin_s  = (state_s == ST_ADDR);
    // Store: MDR takes the bus in ADDR; read: MDR takes memory in CAPTURE
    mdrin_s  = ((state_s == ST_ADDR) & cur_we_s) | (state_s == ST_CAPTURE);
    read_s   = (state_s == ST_CAPTURE);
    mem_rd_s = (state_s == ST_ACCESS) & ~cur_we_s;
    mem_wr_s = (state_s == ST_ACCESS) &  cur_we_s;
    done_s   = (state_s == ST_DONE);
    err_s    = timeout_s;
  end

  // Output register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      busy   <= 1'b0;
      if_gnt <= 1'b0;
      ls_gnt <= 1'b0;
      MARin  <= 1'b0;
      MDRin  <= 1'b0;
      Read   <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      busy   <= busy_s;
      if_gnt <= if_gnt_s;
      ls_gnt <= ls_gnt_s;
      MARin  <= marin_s;
      MDRin  <= mdrin_s;
      Read   <= read_s;
      mem_rd <= mem_rd_s;
      mem_wr <= mem_wr_s;
      done   <= done_s;
      err    <= err_s;
    end
  end

endmodule
